// File: rtl/ext_code_pkg.sv
// Shared defaults, FSM state type and helpers for the external-code loader.
package ext_code_pkg;

    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_DEPTH     = 8;
    localparam int unsigned DEF_SETUP_CYC = 1;
    localparam int unsigned DEF_PULSE_CYC = 2;
    localparam int unsigned DEF_HOLD_CYC  = 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        DONE
    } loaderState_t;

    // Largest of three phase lengths, used to size the phase counter.
    function automatic int unsigned maxOf3(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ext_code_buf.sv
// Local code buffer: register array, fill count and sticky overflow flag.
module ext_code_buf
    import ext_code_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1,
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iWrEn,
    input  logic [DATA_W-1:0] iWrData,
    input  logic              iWrDrop,
    input  logic              iFlush,
    input  logic              iClear,
    input  logic [IDX_W-1:0]  iRdIdx,
    output logic [DATA_W-1:0] oRdData_c,
    output logic [CNT_W-1:0]  oCount,
    output logic              oOverflow
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Word storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge iClk) begin
        if (iWrEn) begin
            mem[oCount[IDX_W-1:0]] <= iWrData;
        end
    end

    // Fill count and sticky overflow; clear wins over flush, writes and drops.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            oCount    <= '0;
            oOverflow <= 1'b0;
        end else if (iClear) begin
            oCount    <= '0;
            oOverflow <= 1'b0;
        end else begin
            if (iFlush) begin
                oCount <= '0;
            end else if (iWrEn) begin
                oCount <= oCount + CNT_W'(1);
            end
            if (iWrDrop) begin
                oOverflow <= 1'b1;
            end
        end
    end

    // Indexed read with forwarding so a word written in the commit cycle is visible.
    always_comb begin
        oRdData_c = mem[iRdIdx];
        if (iWrEn && (CNT_W'(iRdIdx) == oCount)) begin
            oRdData_c = iWrData;
        end
    end

endmodule

// File: rtl/ext_code_loader.sv
// Host-side writer for the external-code LIFO store: buffers codes, then
// downloads them last-first as timed SET_DATA / SET_FLAG strobes.
module ext_code_loader
    import ext_code_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
    parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
    parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic                   iClk,
    input  logic                   iRst_n,
    input  logic                   iWr_valid,
    input  logic [DATA_W-1:0]      iWr_data,
    output logic                   oWr_ready,
    input  logic                   iCommit,
    input  logic                   iClear,
    output logic                   oSET_FLAG,
    output logic [DATA_W-1:0]      oSET_DATA,
    output logic                   oBusy,
    output logic [$clog2(DEPTH):0] oCount,
    output logic                   oDone,
    output logic                   oOverflow
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PH_W  = $clog2(maxOf3(SETUP_CYC, PULSE_CYC, HOLD_CYC)) + 1;

    loaderState_t      state;
    loaderState_t      stateNext;
    logic [PH_W-1:0]   phase;
    logic [PH_W-1:0]   phaseNext;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  ptrNext;
    logic              flagNext;
    logic [DATA_W-1:0] dataNext;
    logic              doneNext;
    logic              busyNext;
    logic              flush;
    logic              wrAccept;
    logic              wrDrop;
    logic [CNT_W-1:0]  countNext;
    logic [DATA_W-1:0] rdData;

    // Host write handshake: only in IDLE, with room, and out of reset.
    assign oWr_ready = (state == IDLE) && (oCount < CNT_W'(DEPTH)) && iRst_n;
    assign wrAccept  = iWr_valid && oWr_ready && !iClear;
    assign wrDrop    = iWr_valid && (state == IDLE) && (oCount == CNT_W'(DEPTH)) && !iClear;
    assign countNext = oCount + CNT_W'(wrAccept);

    ext_code_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iWrEn     (wrAccept),
        .iWrData   (iWr_data),
        .iWrDrop   (wrDrop),
        .iFlush    (flush),
        .iClear    (iClear),
        .iRdIdx    (ptrNext),
        .oRdData_c (rdData),
        .oCount    (oCount),
        .oOverflow (oOverflow)
    );

    // State, phase, pointer and registered strobe outputs.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state     <= IDLE;
            phase     <= '0;
            ptr       <= '0;
            oSET_FLAG <= 1'b0;
            oSET_DATA <= '0;
            oDone     <= 1'b0;
            oBusy     <= 1'b0;
        end else begin
            state     <= stateNext;
            phase     <= phaseNext;
            ptr       <= ptrNext;
            oSET_FLAG <= flagNext;
            oSET_DATA <= dataNext;
            oDone     <= doneNext;
            oBusy     <= busyNext;
        end
    end

    // Next-state sequencing of the download and its strobe timing.
    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        phaseNext = (phase == '0) ? '0 : phase - PH_W'(1);
        flush     = 1'b0;

        unique case (state)
            IDLE: begin
                if (iCommit) begin
                    if (countNext == '0) begin
                        stateNext = DONE;
                    end else begin
                        stateNext = SETUP;
                        ptrNext   = IDX_W'(countNext - CNT_W'(1));
                    end
                end
            end
            SETUP: begin
                if (phase == '0) stateNext = PULSE;
            end
            PULSE: begin
                if (phase == '0) stateNext = HOLD;
            end
            HOLD: begin
                if (phase == '0) begin
                    if (ptr == '0) begin
                        stateNext = DONE;
                    end else begin
                        stateNext = SETUP;
                        ptrNext   = ptr - IDX_W'(1);
                    end
                end
            end
            DONE: begin
                stateNext = IDLE;
                flush     = 1'b1;
            end
            default: stateNext = IDLE;
        endcase

        if (iClear) begin
            stateNext = IDLE;
        end

        // Phase counter reloads whenever a new state is entered.
        if (stateNext != state) begin
            unique case (stateNext)
                SETUP:   phaseNext = PH_W'(SETUP_CYC - 1);
                PULSE:   phaseNext = PH_W'(PULSE_CYC - 1);
                HOLD:    phaseNext = PH_W'(HOLD_CYC - 1);
                default: phaseNext = '0;
            endcase
        end

        flagNext = (stateNext == PULSE);
        doneNext = (stateNext == DONE);
        busyNext = (stateNext != IDLE);

        dataNext = oSET_DATA;
        if (iClear || (stateNext == DONE)) begin
            dataNext = '0;
        end else if ((stateNext == SETUP) && (state != SETUP)) begin
            dataNext = rdData;
        end
    end

endmodule

// File: tb/tb_ext_code_loader.sv
// Self-checking bench for ext_code_loader against a queue-based model.
module tb_ext_code_loader;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned S     = 1;
    localparam int unsigned P     = 2;
    localparam int unsigned H     = 1;
    localparam int          WORD  = S + P + H;

    logic          iClk = 1'b0;
    logic          iRst_n;
    logic          iWr_valid;
    logic [DW-1:0] iWr_data;
    logic          oWr_ready;
    logic          iCommit;
    logic          iClear;
    logic          oSET_FLAG;
    logic [DW-1:0] oSET_DATA;
    logic          oBusy;
    logic [3:0]    oCount;
    logic          oDone;
    logic          oOverflow;

    ext_code_loader #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .SETUP_CYC (S),
        .PULSE_CYC (P),
        .HOLD_CYC  (H)
    ) dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iWr_valid (iWr_valid),
        .iWr_data  (iWr_data),
        .oWr_ready (oWr_ready),
        .iCommit   (iCommit),
        .iClear    (iClear),
        .oSET_FLAG (oSET_FLAG),
        .oSET_DATA (oSET_DATA),
        .oBusy     (oBusy),
        .oCount    (oCount),
        .oDone     (oDone),
        .oOverflow (oOverflow)
    );

    always #5 iClk = ~iClk;

    int nChecks = 0;
    int nErrors = 0;

    // Behavioural model: host-order list of buffered words plus overflow flag.
    logic [DW-1:0] modelQ[$];
    logic          modelOvf;

    // Observations gathered during a download.
    logic [DW-1:0] strobes[$];
    int            pulseLens[$];
    int            doneCycle, doneCount, stabErr, busyCycles, countAfter, countMoved;
    logic          idleAfter;

    task automatic model_write(input logic [DW-1:0] w);
        if (modelQ.size() < DEPTH) modelQ.push_back(w);
        else modelOvf = 1'b1;
    endtask

    task automatic write_word(input logic [DW-1:0] w);
        @(negedge iClk);
        iWr_valid = 1'b1;
        iWr_data  = w;
        model_write(w);
    endtask

    task automatic end_writes();
        @(negedge iClk);
        iWr_valid = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge iClk);
        iClear = 1'b1;
        @(negedge iClk);
        iClear = 1'b0;
        modelQ.delete();
        modelOvf = 1'b0;
    endtask

    // Observe a download started by iCommit driven at the current negedge.
    task automatic collect(input int maxCyc, input bit busyWrites);
        logic          pf;
        logic [DW-1:0] pd;
        int            run;
        int            startCount;
        bit            seenDone;
        strobes.delete();
        pulseLens.delete();
        doneCycle = -1; doneCount = 0; stabErr = 0; busyCycles = 0;
        countAfter = -1; countMoved = 0; idleAfter = 1'b0;
        pf = oSET_FLAG; pd = oSET_DATA; run = 0; startCount = -1; seenDone = 0;
        for (int k = 1; k <= maxCyc; k++) begin
            @(negedge iClk);
            if (oSET_FLAG && !pf) begin
                strobes.push_back(oSET_DATA);
                run = 1;
                if (oSET_DATA !== pd) stabErr++;
            end else if (oSET_FLAG) begin
                run++;
                if (oSET_DATA !== pd) stabErr++;
            end else if (pf) begin
                pulseLens.push_back(run);
                if (oSET_DATA !== pd) stabErr++;
            end
            if (oBusy) busyCycles++;
            if (k == 1) startCount = int'(oCount);
            else if (oBusy && (int'(oCount) != startCount)) countMoved++;
            if (oDone) begin doneCount++; doneCycle = k; end
            pf = oSET_FLAG;
            pd = oSET_DATA;
            iCommit = 1'b0;
            if (seenDone) begin
                countAfter = int'(oCount);
                idleAfter  = !oBusy && oWr_ready;
                break;
            end
            if (oDone) seenDone = 1;
            if (busyWrites && oBusy && !oDone) begin
                iWr_valid = 1'b1;
                iWr_data  = $urandom;
            end else begin
                iWr_valid = 1'b0;
            end
        end
        iWr_valid = 1'b0;
        iCommit   = 1'b0;
    endtask

    task automatic test_reset();
        iRst_n = 1'b0; iWr_valid = 1'b0; iWr_data = '0; iCommit = 1'b0; iClear = 1'b0;
        modelQ.delete(); modelOvf = 1'b0;
        repeat (2) @(negedge iClk);
        nChecks++;
        if ({oSET_FLAG, oSET_DATA, oBusy, oCount, oDone, oOverflow, oWr_ready} !== '0) begin
            nErrors++;
            $display("FAIL reset_outputs: got flag=%b data=%h busy=%b count=%0d done=%b ovf=%b rdy=%b, want all 0",
                     oSET_FLAG, oSET_DATA, oBusy, oCount, oDone, oOverflow, oWr_ready);
        end
        iRst_n = 1'b1;
        @(negedge iClk);
        nChecks++;
        if ({oWr_ready, oCount} !== {1'b1, 4'd0}) begin
            nErrors++;
            $display("FAIL reset_release: got rdy=%b count=%0d, want rdy=1 count=0", oWr_ready, oCount);
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp[$];
        write_word(32'h11); write_word(32'h22); write_word(32'h33);
        end_writes();
        nChecks++;
        if (oCount !== 4'd3) begin nErrors++; $display("FAIL basic_count: got %0d want 3", oCount); end
        for (int i = modelQ.size() - 1; i >= 0; i--) exp.push_back(modelQ[i]);
        iCommit = 1'b1;
        collect(60, 1'b0);
        nChecks++;
        if (strobes.size() != exp.size()) begin nErrors++; $display("FAIL basic_nstrobes: got %0d want %0d", strobes.size(), exp.size()); end
        for (int i = 0; i < strobes.size() && i < exp.size(); i++) begin
            nChecks++;
            if (strobes[i] !== exp[i]) begin nErrors++; $display("FAIL basic_strobe%0d: got %h want %h", i, strobes[i], exp[i]); end
        end
        for (int i = 0; i < pulseLens.size(); i++) begin
            nChecks++;
            if (pulseLens[i] != P) begin nErrors++; $display("FAIL basic_pulselen%0d: got %0d want %0d", i, pulseLens[i], P); end
        end
        nChecks++;
        if (stabErr != 0) begin nErrors++; $display("FAIL basic_stability: got %0d violations want 0", stabErr); end
        nChecks++;
        if (doneCycle != 1 + 3 * WORD) begin nErrors++; $display("FAIL basic_done_cycle: got %0d want %0d", doneCycle, 1 + 3 * WORD); end
        nChecks++;
        if (doneCount != 1) begin nErrors++; $display("FAIL basic_done_pulses: got %0d want 1", doneCount); end
        nChecks++;
        if ({idleAfter, countAfter} !== {1'b1, 32'sd0}) begin nErrors++; $display("FAIL basic_after: got idle=%b count=%0d want idle=1 count=0", idleAfter, countAfter); end
        modelQ.delete();
    endtask

    task automatic test_overflow();
        logic [DW-1:0] exp[$];
        for (int i = 1; i <= 9; i++) write_word(DW'(i));
        end_writes();
        nChecks++;
        if ({oCount, oOverflow} !== {4'(modelQ.size()), modelOvf}) begin
            nErrors++; $display("FAIL ovf_state: got count=%0d ovf=%b want count=%0d ovf=%b", oCount, oOverflow, modelQ.size(), modelOvf);
        end
        for (int i = modelQ.size() - 1; i >= 0; i--) exp.push_back(modelQ[i]);
        iCommit = 1'b1;
        collect(100, 1'b0);
        nChecks++;
        if (strobes.size() != exp.size()) begin nErrors++; $display("FAIL ovf_nstrobes: got %0d want %0d", strobes.size(), exp.size()); end
        for (int i = 0; i < strobes.size() && i < exp.size(); i++) begin
            nChecks++;
            if (strobes[i] !== exp[i]) begin nErrors++; $display("FAIL ovf_strobe%0d: got %h want %h", i, strobes[i], exp[i]); end
        end
        nChecks++;
        if (doneCycle != 1 + int'(exp.size()) * WORD) begin nErrors++; $display("FAIL ovf_done_cycle: got %0d want %0d", doneCycle, 1 + int'(exp.size()) * WORD); end
        nChecks++;
        if (oOverflow !== 1'b1) begin nErrors++; $display("FAIL ovf_sticky: got %b want 1", oOverflow); end
        do_clear();
        nChecks++;
        if ({oOverflow, oCount} !== 5'd0) begin nErrors++; $display("FAIL ovf_clear: got ovf=%b count=%0d want 0/0", oOverflow, oCount); end
    endtask

    task automatic test_empty_commit();
        @(negedge iClk);
        iCommit = 1'b1;
        collect(10, 1'b0);
        nChecks++;
        if (doneCycle != 1) begin nErrors++; $display("FAIL empty_done_cycle: got %0d want 1", doneCycle); end
        nChecks++;
        if (strobes.size() != 0) begin nErrors++; $display("FAIL empty_strobes: got %0d want 0", strobes.size()); end
        nChecks++;
        if (busyCycles != 1) begin nErrors++; $display("FAIL empty_busy_cycles: got %0d want 1", busyCycles); end
    endtask

    task automatic test_clear_abort();
        int  rises;
        int  riseCycle;
        bit  sawDone;
        logic pf;
        for (int i = 0; i < 4; i++) write_word($urandom);
        end_writes();
        iCommit = 1'b1;
        rises = 0; riseCycle = -1; pf = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge iClk);
            iCommit = 1'b0;
            if (oSET_FLAG && !pf) rises++;
            pf = oSET_FLAG;
            if (rises == 2) begin riseCycle = k; break; end
        end
        nChecks++;
        if (riseCycle != 1 + WORD + int'(S)) begin nErrors++; $display("FAIL abort_second_rise: got cycle %0d want %0d", riseCycle, 1 + WORD + int'(S)); end
        iClear = 1'b1;
        @(negedge iClk);
        iClear = 1'b0;
        nChecks++;
        if ({oSET_FLAG, oBusy, oCount, oSET_DATA, oDone} !== '0) begin
            nErrors++; $display("FAIL abort_state: got flag=%b busy=%b count=%0d data=%h done=%b want all 0", oSET_FLAG, oBusy, oCount, oSET_DATA, oDone);
        end
        sawDone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge iClk);
            if (oDone || oSET_FLAG) sawDone = 1;
        end
        nChecks++;
        if (sawDone) begin nErrors++; $display("FAIL abort_quiet: got done/flag activity after clear, want none"); end
        modelQ.delete(); modelOvf = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp[$];
        write_word($urandom); write_word($urandom);
        @(negedge iClk);
        iWr_valid = 1'b1; iWr_data = 32'hAA; iCommit = 1'b1;
        model_write(32'hAA);
        for (int i = modelQ.size() - 1; i >= 0; i--) exp.push_back(modelQ[i]);
        collect(60, 1'b1);
        nChecks++;
        if (strobes.size() != exp.size()) begin nErrors++; $display("FAIL b2b_nstrobes: got %0d want %0d", strobes.size(), exp.size()); end
        for (int i = 0; i < strobes.size() && i < exp.size(); i++) begin
            nChecks++;
            if (strobes[i] !== exp[i]) begin nErrors++; $display("FAIL b2b_strobe%0d: got %h want %h", i, strobes[i], exp[i]); end
        end
        nChecks++;
        if (countMoved != 0) begin nErrors++; $display("FAIL b2b_count_busy: got %0d count changes while busy want 0", countMoved); end
        nChecks++;
        if (doneCycle != 1 + 3 * WORD) begin nErrors++; $display("FAIL b2b_done_cycle: got %0d want %0d", doneCycle, 1 + 3 * WORD); end
        nChecks++;
        if ({oOverflow, countAfter} !== {1'b0, 32'sd0}) begin nErrors++; $display("FAIL b2b_after: got ovf=%b count=%0d want 0/0", oOverflow, countAfter); end
        modelQ.delete();
    endtask

    task automatic test_reset_mid_hold();
        logic [DW-1:0] w;
        write_word($urandom); write_word($urandom);
        end_writes();
        iCommit = 1'b1;
        for (int k = 1; k <= int'(S + P + 1); k++) begin
            @(negedge iClk);
            iCommit = 1'b0;
        end
        nChecks++;
        if ({oSET_FLAG, oBusy} !== 2'b01) begin nErrors++; $display("FAIL midhold_pre: got flag=%b busy=%b want 0/1", oSET_FLAG, oBusy); end
        iRst_n = 1'b0;
        @(negedge iClk);
        nChecks++;
        if ({oSET_FLAG, oSET_DATA, oBusy, oCount, oDone, oOverflow, oWr_ready} !== '0) begin
            nErrors++; $display("FAIL midhold_reset: got flag=%b data=%h busy=%b count=%0d done=%b ovf=%b rdy=%b want all 0",
                                oSET_FLAG, oSET_DATA, oBusy, oCount, oDone, oOverflow, oWr_ready);
        end
        iRst_n = 1'b1;
        modelQ.delete(); modelOvf = 1'b0;
        w = $urandom;
        write_word(w);
        end_writes();
        iCommit = 1'b1;
        collect(30, 1'b0);
        nChecks++;
        if ({strobes.size(), doneCycle} != {32'd1, 32'(1 + WORD)}) begin
            nErrors++; $display("FAIL midhold_fresh: got nstrobes=%0d done=%0d want 1/%0d", strobes.size(), doneCycle, 1 + WORD);
        end else begin
            nChecks++;
            if (strobes[0] !== w) begin nErrors++; $display("FAIL midhold_fresh_data: got %h want %h", strobes[0], w); end
        end
        modelQ.delete();
    endtask

    task automatic test_random();
        logic [DW-1:0] exp[$];
        int n;
        for (int it = 0; it < 6; it++) begin
            do_clear();
            n = $urandom_range(0, 10);
            for (int i = 0; i < n; i++) write_word($urandom);
            end_writes();
            exp.delete();
            for (int i = modelQ.size() - 1; i >= 0; i--) exp.push_back(modelQ[i]);
            nChecks++;
            if (oOverflow !== modelOvf) begin nErrors++; $display("FAIL rand%0d_ovf: got %b want %b", it, oOverflow, modelOvf); end
            iCommit = 1'b1;
            collect(120, 1'b0);
            nChecks++;
            if (strobes.size() != exp.size()) begin nErrors++; $display("FAIL rand%0d_nstrobes: got %0d want %0d", it, strobes.size(), exp.size()); end
            for (int i = 0; i < strobes.size() && i < exp.size(); i++) begin
                nChecks++;
                if (strobes[i] !== exp[i]) begin nErrors++; $display("FAIL rand%0d_strobe%0d: got %h want %h", it, i, strobes[i], exp[i]); end
            end
            nChecks++;
            if (doneCycle != 1 + int'(exp.size()) * WORD) begin nErrors++; $display("FAIL rand%0d_done_cycle: got %0d want %0d", it, doneCycle, 1 + int'(exp.size()) * WORD); end
            nChecks++;
            if (stabErr != 0) begin nErrors++; $display("FAIL rand%0d_stability: got %0d violations want 0", it, stabErr); end
            modelQ.delete();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_empty_commit();
        test_clear_abort();
        test_back_to_back();
        test_reset_mid_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ext_code_loader.md
# ext_code_loader

Host-side writer for the external-code LIFO store. Accepts up to DEPTH 32-bit codes from a valid/ready word interface and buffers them locally. On a commit it downloads them into the store as timed SET_FLAG/SET_DATA strobes. The store pops last-written first, so the loader transmits in reverse order, and the store then replays codes in host order on each trigger.

## Interface
Parameters:
- DATA_W, 32, code width
- DEPTH, 8, local buffer entries; must equal store depth
- SETUP_CYC, 1, cycles oSET_DATA is stable before oSET_FLAG rises (≥1)
- PULSE_CYC, 2, cycles oSET_FLAG stays high (≥1)
- HOLD_CYC, 1, cycles oSET_DATA is held after oSET_FLAG falls (≥1)

Ports:
- iClk  in  1  single clock; all logic on its rising edge
- iRst_n  in  1  synchronous, active-low reset
- iWr_valid  in  1  host word valid
- iWr_data  in  DATA_W  host word
- oWr_ready  out  1  combinational: state IDLE, count<DEPTH, iRst_n=1
- iCommit  in  1  single-cycle request to download the buffer
- iClear  in  1  clears buffer and overflow; aborts a download
- oSET_FLAG  out  1  store write strobe, registered
- oSET_DATA  out  DATA_W  store write data, registered
- oBusy  out  1  high in every state except IDLE
- oCount  out  $clog2(DEPTH)+1  words buffered
- oDone  out  1  one-cycle pulse at end of download
- oOverflow  out  1  sticky: a write arrived while count==DEPTH in IDLE

## Operation
- Reset (iRst_n=0 at an edge) zeroes all outputs and count, and puts the FSM in IDLE. Buffer contents are don't-care.
- IDLE, iWr_valid & oWr_ready: buf[count]←iWr_data, count+1.
- IDLE, iWr_valid with count==DEPTH: word dropped, oOverflow←1.
- Not IDLE: writes ignored; oOverflow is not set.
- iCommit in IDLE: same-cycle accepted write is included. ptr←count_next−1. If count_next==0, go to DONE, else SETUP.
- iCommit while busy: ignored.
- FSM states:
  - SETUP: oSET_DATA=buf[ptr], oSET_FLAG=0, lasting SETUP_CYC cycles.
  - PULSE: oSET_FLAG=1, lasting PULSE_CYC cycles.
  - HOLD: oSET_FLAG=0, data held, lasting HOLD_CYC cycles. Then if ptr==0 go to DONE, else ptr−1 and go to SETUP.
  - DONE: oDone=1 for one cycle, count←0, oSET_DATA←0, go to IDLE.
- iClear has priority over iCommit and writes. In any state it does the following next edge: FSM←IDLE, count←0, oOverflow←0, oSET_FLAG←0, oSET_DATA←0. No oDone is produced.
- Phase counter width is $clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC))+1 and reloads on every state entry.

## Timing
- Commit sampled at edge 0 gives oBusy=1 and SETUP with word N−1 on oSET_DATA from edge 1.
- Per word, SETUP_CYC+PULSE_CYC+HOLD_CYC cycles; 4 at defaults.
- oSET_FLAG rises at edge 1+SETUP_CYC for the first word.
- oDone rises at edge 1+N·(S+P+H) and lasts one cycle.
- oBusy falls and oWr_ready rises the cycle after oDone.
- Empty commit: oDone at edge 1, no strobes.
- oSET_DATA never changes while oSET_FLAG=1, nor in the cycle before it rises or the cycle after it falls.
- oCount updates one cycle after an accepted write.

## Structure
- Package ext_code_pkg holds:
  - DATA_W and DEPTH defaults
  - state enum {IDLE, SETUP, PULSE, HOLD, DONE}
  - timing defaults
- Sub-module ext_code_buf owns the register array, count, overflow flag and clear. Its interfaces are write port, indexed read port and clear.
- The FSM and phase counter live in the top.

## Test plan
- Reset then write 0x11,0x22,0x33, commit: SET strobes carry 0x33,0x22,0x11 in that order. Each strobe has flag high 2 cycles with data stable ±1 cycle. oDone at edge 13; oCount returns to 0.
- Write 9 words 0x1..0x9: oCount=8, oOverflow=1, 0x9 absent. Commit sends 0x8 first. iClear then clears oOverflow.
- Commit with empty buffer: oDone at edge 1, oSET_FLAG never high, oBusy high for exactly 1 cycle.
- iClear asserted during the second PULSE of a 4-word download: next cycle oSET_FLAG=0, oBusy=0, oCount=0, no oDone.
- iWr_valid(0xAA) and iCommit in the same cycle with 2 words buffered: 3 strobes, first data 0xAA. iWr_valid while busy is ignored and oCount is unchanged.
- iRst_n=0 mid-HOLD: next edge all outputs 0, IDLE. A fresh write/commit afterward works normally.
